kanagawa_programmable_delay_fifo: RTL and testbench

Runtime-programmable delay line: every cycle one word enters, and the word that entered D+1 cycles earlier leaves. D is loadable at runtime from 0 to MAX_DELAY. Successor to the fixed-delay FIFO. It adds three things: a per-word valid qualifier, a runtime-selectable delay, and a warm-up guard so stale storage contents are never reported as valid. It sits in compiler-generated pipelines wherever a balancing delay must be retuned without re-synthesis.

---
 rtl/kanagawa_programmable_delay_fifo.sv | 178 +++++++++++++++++
 tb/tb_kanagawa_programmable_delay_fifo.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kanagawa_programmable_delay_fifo.sv
// -----------------------------------------------------------------------------
// kanagawa_programmable_delay_fifo
//
// Runtime-programmable delay line. Every cycle one {valid, data} word enters a
// circular buffer. The word that entered D+1 cycles earlier leaves through a
// single output register. D can be reloaded at any time. After each reload,
// and after reset, a warm-up counter masks the output so that stale buffer
// contents are never reported as valid. The buffer itself is never cleared.
//
// Parameters
//   WIDTH         data word width
//   MAX_DELAY     largest programmable D
//   RESET_DELAY   D after reset
//   USE_LUTRAM    1 = distributed (MLAB) storage, 0 = block RAM
//   DEVICE_FAMILY target family; selects the block RAM flavour
//   DW            width of the delay fields, $clog2(MAX_DELAY+1)
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset
//   delay_in      requested delay D (values above MAX_DELAY are clamped)
//   delay_load    latch delay_in this cycle and restart warm-up
//   input_valid   qualifier for data_in
//   data_in       input word
//   output_valid  qualifier for data_out
//   data_out      delayed word, forced to 0 when output_valid=0
//   delay_busy    warm-up in progress
//   delay_current active D
// -----------------------------------------------------------------------------
module kanagawa_programmable_delay_fifo #(
    parameter int    WIDTH         = 16,
    parameter int    MAX_DELAY     = 64,
    parameter int    RESET_DELAY   = 8,
    parameter int    USE_LUTRAM    = 1,
    parameter string DEVICE_FAMILY = "Stratix10",
    localparam int   DW            = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    delay_in,
    input  logic             delay_load,
    input  logic             input_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             output_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             delay_busy,
    output logic [DW-1:0]    delay_current
);

    // The buffer depth is a power of two, so pointer arithmetic wraps naturally.
    localparam int AW    = DW;
    localparam int DEPTH = 1 << AW;

    localparam logic [DW-1:0] MAX_D   = DW'(MAX_DELAY);
    localparam logic [DW-1:0] RESET_D = DW'(RESET_DELAY);

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   d_q, d_d;
    logic [DW:0]     cnt_q, cnt_d;
    logic [AW-1:0]   wr_ptr_q;
    logic [DW:0]     d_plus1;
    logic            busy;

    logic [AW-1:0]   rd_addr;
    logic [WIDTH:0]  wr_word;
    logic [WIDTH:0]  ram_q;
    logic [WIDTH:0]  byp_q;
    logic            byp_sel_q;
    logic [WIDTH:0]  out_word;

    assign d_plus1 = {1'b0, d_q} + (DW+1)'(1);
    assign busy    = (cnt_q < d_plus1);
    assign rd_addr = wr_ptr_q - d_q;
    assign wr_word = {input_valid, data_in};

    // -------------------------------------------------------------------------
    // Control: delay register, warm-up counter, WARM/RUN state
    // -------------------------------------------------------------------------
    always_comb begin
        d_d     = d_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (delay_load) begin
            // Clamp out-of-range requests instead of letting them wrap.
            d_d     = (delay_in > MAX_D) ? MAX_D : delay_in;
            cnt_d   = '0;
            state_d = WARM;
        end else begin
            case (state_q)
                WARM: begin
                    if (busy) begin
                        cnt_d = cnt_q + (DW+1)'(1);
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = WARM;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q      <= RESET_D;
            cnt_q    <= '0;
            state_q  <= WARM;
            wr_ptr_q <= '0;
        end else begin
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_q + AW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Storage: written every cycle, registered read with old-data semantics.
    // For D >= 1 the addressed entry was written D edges earlier, so a
    // read-during-write on the same address can never occur.
    // -------------------------------------------------------------------------
    generate
        if (USE_LUTRAM != 0) begin : g_lutram
            (* ramstyle = "MLAB, no_rw_check" *) logic [WIDTH:0] mem_q [DEPTH];
            always_ff @(posedge clk) begin
                mem_q[wr_ptr_q] <= wr_word;
                ram_q           <= mem_q[rd_addr];
            end
        end else if (DEVICE_FAMILY == "Cyclone V") begin : g_m10k
            (* ramstyle = "M10K, no_rw_check" *) logic [WIDTH:0] mem_q [DEPTH];
            always_ff @(posedge clk) begin
                mem_q[wr_ptr_q] <= wr_word;
                ram_q           <= mem_q[rd_addr];
            end
        end else begin : g_m20k
            (* ramstyle = "M20K, no_rw_check" *) logic [WIDTH:0] mem_q [DEPTH];
            always_ff @(posedge clk) begin
                mem_q[wr_ptr_q] <= wr_word;
                ram_q           <= mem_q[rd_addr];
            end
        end
    endgenerate

    // D=0 means "this cycle's input, one register later". The RAM cannot
    // return the word being written in the same edge, so a bypass register
    // carries it instead. Its select is captured with the same edge as the
    // data, so a delay reload stays consistent (and is masked by warm-up).
    always_ff @(posedge clk) begin
        byp_q     <= wr_word;
        byp_sel_q <= (d_q == '0);
    end

    assign out_word = byp_sel_q ? byp_q : ram_q;

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign output_valid  = out_word[WIDTH] & ~busy;
    assign delay_busy    = busy;
    assign delay_current = d_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_dout
            assign data_out[gi] = out_word[gi] & output_valid;
        end
    endgenerate

endmodule

// File: tb/tb_kanagawa_programmable_delay_fifo.sv
module tb_kanagawa_programmable_delay_fifo;

    localparam int WIDTH = 16;
    localparam int DW    = 7;   // $clog2(64+1)

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DW-1:0]    delay_in = '0;
    logic             delay_load = 1'b0;
    logic             input_valid = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             output_valid;
    logic [WIDTH-1:0] data_out;
    logic             delay_busy;
    logic [DW-1:0]    delay_current;

    int errors = 0;
    int checks = 0;

    kanagawa_programmable_delay_fifo #(
        .WIDTH         (16),
        .MAX_DELAY     (64),
        .RESET_DELAY   (8),
        .USE_LUTRAM    (1),
        .DEVICE_FAMILY ("Stratix10")
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .delay_in      (delay_in),
        .delay_load    (delay_load),
        .input_valid   (input_valid),
        .data_in       (data_in),
        .output_valid  (output_valid),
        .data_out      (data_out),
        .delay_busy    (delay_busy),
        .delay_current (delay_current)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 (first cycle with rst=0).
    task automatic do_reset();
        rst        = 1'b1;
        delay_load = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; delay_load = 1'b1; delay_in = 7'd2;
        input_valid = 1'b1; data_in = 16'hABCD;
        tick(); tick();
        $display("reset: rst=1 with delay_load(2) held");
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL rst_ov: got %0b want 0", output_valid); end
        checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL rst_dout: got %h want 0000", data_out); end
        checks++; if (delay_busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %0b want 1", delay_busy); end
        checks++; if (delay_current !== 7'd8) begin errors++; $display("FAIL rst_dcur: got %0d want 8", delay_current); end
        rst = 1'b0; delay_load = 1'b0;
        $display("reset: first cycle after rst");
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL rst0_ov: got %0b want 0", output_valid); end
        checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL rst0_dout: got %h want 0000", data_out); end
        checks++; if (delay_busy !== 1'b1) begin errors++; $display("FAIL rst0_busy: got %0b want 1", delay_busy); end
        checks++; if (delay_current !== 7'd8) begin errors++; $display("FAIL rst0_dcur: got %0d want 8", delay_current); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_ramp_and_change();
        logic             exp_v;
        logic [WIDTH-1:0] exp_d;
        do_reset();
        $display("ramp: D=8, delay_load(3) at i=200");
        for (int i = 0; i < 1024; i++) begin
            data_in = 16'(i); input_valid = 1'b1;
            delay_load = (i == 200); delay_in = 7'd3;
            if (i <= 8)        begin exp_v = 1'b0; exp_d = '0; end
            else if (i <= 200) begin exp_v = 1'b1; exp_d = 16'(i - 9); end
            else if (i <= 204) begin exp_v = 1'b0; exp_d = '0; end
            else               begin exp_v = 1'b1; exp_d = 16'(i - 4); end
            checks++;
            if ({output_valid, data_out} !== {exp_v, exp_d}) begin
                errors++;
                $display("FAIL ramp i=%0d: got v=%0b d=%0d want v=%0b d=%0d", i, output_valid, data_out, exp_v, exp_d);
            end
            if (i >= 201 && i <= 204) begin
                checks++; if (delay_busy !== 1'b1) begin errors++; $display("FAIL ramp_busy i=%0d: got %0b want 1", i, delay_busy); end
            end
            if (i == 205) begin
                checks++; if (delay_busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_end: got %0b want 0", delay_busy); end
            end
            if (i == 201) begin
                checks++; if (delay_current !== 7'd3) begin errors++; $display("FAIL ramp_dcur: got %0d want 3", delay_current); end
            end
            tick();
        end
        delay_load = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_d0();
        logic             exp_v;
        logic [WIDTH-1:0] exp_d;
        do_reset();
        $display("d0: delay_load(0) at i=20");
        for (int i = 0; i < 60; i++) begin
            data_in = 16'(i + 500); input_valid = 1'b1;
            delay_load = (i == 20); delay_in = 7'd0;
            if (i <= 8)       begin exp_v = 1'b0; exp_d = '0; end
            else if (i <= 20) begin exp_v = 1'b1; exp_d = 16'(i - 9 + 500); end
            else if (i == 21) begin exp_v = 1'b0; exp_d = '0; end
            else              begin exp_v = 1'b1; exp_d = 16'(i - 1 + 500); end
            checks++;
            if ({output_valid, data_out} !== {exp_v, exp_d}) begin
                errors++;
                $display("FAIL d0 i=%0d: got v=%0b d=%0d want v=%0b d=%0d", i, output_valid, data_out, exp_v, exp_d);
            end
            if (i == 21 || i == 22) begin
                checks++;
                if (delay_busy !== (i == 21)) begin errors++; $display("FAIL d0_busy i=%0d: got %0b want %0b", i, delay_busy, (i == 21)); end
            end
            tick();
        end
        delay_load = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_dmax();
        logic             exp_v;
        logic [WIDTH-1:0] exp_d;
        do_reset();
        $display("dmax: delay_load(64) at i=0, 1024 cycles");
        for (int i = 0; i < 1024; i++) begin
            data_in = 16'(i * 3); input_valid = 1'b1;
            delay_load = (i == 0); delay_in = 7'd64;
            if (i <= 65) begin exp_v = 1'b0; exp_d = '0; end
            else         begin exp_v = 1'b1; exp_d = 16'((i - 65) * 3); end
            checks++;
            if ({output_valid, data_out} !== {exp_v, exp_d}) begin
                errors++;
                $display("FAIL dmax i=%0d: got v=%0b d=%0d want v=%0b d=%0d", i, output_valid, data_out, exp_v, exp_d);
            end
            if (i == 1) begin
                checks++; if (delay_current !== 7'd64) begin errors++; $display("FAIL dmax_dcur: got %0d want 64", delay_current); end
            end
            if (i == 65 || i == 66) begin
                checks++;
                if (delay_busy !== (i == 65)) begin errors++; $display("FAIL dmax_busy i=%0d: got %0b want %0b", i, delay_busy, (i == 65)); end
            end
            tick();
        end
        delay_load = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_clamp();
        do_reset();
        delay_in = 7'd127; delay_load = 1'b1; tick();
        $display("clamp: delay_load(127)");
        checks++; if (delay_current !== 7'd64) begin errors++; $display("FAIL clamp127: got %0d want 64", delay_current); end
        delay_in = 7'd65; tick();
        $display("clamp: delay_load(65)");
        checks++; if (delay_current !== 7'd64) begin errors++; $display("FAIL clamp65: got %0d want 64", delay_current); end
        delay_in = 7'd63; tick();
        $display("clamp: delay_load(63)");
        checks++; if (delay_current !== 7'd63) begin errors++; $display("FAIL clamp63: got %0d want 63", delay_current); end
        delay_load = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_gaps();
        logic             exp_v;
        logic [WIDTH-1:0] exp_d;
        do_reset();
        $display("gaps: D=5, input_valid pattern 1,0,0");
        for (int i = 0; i < 60; i++) begin
            input_valid = ((i % 3) == 0); data_in = 16'(i + 100);
            delay_load = (i == 0); delay_in = 7'd5;
            if (i <= 6) begin
                exp_v = 1'b0; exp_d = '0;
            end else begin
                exp_v = (((i - 6) % 3) == 0);
                exp_d = exp_v ? 16'(i - 6 + 100) : 16'h0;
            end
            checks++;
            if ({output_valid, data_out} !== {exp_v, exp_d}) begin
                errors++;
                $display("FAIL gaps i=%0d: got v=%0b d=%0d want v=%0b d=%0d", i, output_valid, data_out, exp_v, exp_d);
            end
            tick();
        end
        delay_load = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_midstream();
        logic             exp_v;
        logic [WIDTH-1:0] exp_d;
        do_reset();
        $display("midreset: delay_load(3) at i=100, rst at i=500");
        for (int i = 0; i < 600; i++) begin
            data_in = 16'(i); input_valid = 1'b1;
            delay_load = (i == 100); delay_in = 7'd3;
            rst = (i == 500);
            if (i <= 8)        begin exp_v = 1'b0; exp_d = '0; end
            else if (i <= 100) begin exp_v = 1'b1; exp_d = 16'(i - 9); end
            else if (i <= 104) begin exp_v = 1'b0; exp_d = '0; end
            else if (i <= 500) begin exp_v = 1'b1; exp_d = 16'(i - 4); end
            else if (i <= 509) begin exp_v = 1'b0; exp_d = '0; end
            else               begin exp_v = 1'b1; exp_d = 16'(i - 9); end
            checks++;
            if ({output_valid, data_out} !== {exp_v, exp_d}) begin
                errors++;
                $display("FAIL midreset i=%0d: got v=%0b d=%0d want v=%0b d=%0d", i, output_valid, data_out, exp_v, exp_d);
            end
            if (i == 501) begin
                checks++; if (delay_current !== 7'd8) begin errors++; $display("FAIL midreset_dcur: got %0d want 8", delay_current); end
            end
            tick();
        end
        rst = 1'b0; delay_load = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back_loads();
        logic             exp_v;
        logic [WIDTH-1:0] exp_d;
        do_reset();
        $display("loads: delay_load(10) at i=0, delay_load(4) at i=3, delay_load(4) at i=15");
        for (int i = 0; i < 30; i++) begin
            data_in = 16'(i + 200); input_valid = 1'b1;
            delay_load = (i == 0) || (i == 3) || (i == 15);
            delay_in = (i == 0) ? 7'd10 : 7'd4;
            if (i <= 8)       begin exp_v = 1'b0; exp_d = '0; end
            else if (i <= 15) begin exp_v = 1'b1; exp_d = 16'(i - 5 + 200); end
            else if (i <= 20) begin exp_v = 1'b0; exp_d = '0; end
            else              begin exp_v = 1'b1; exp_d = 16'(i - 5 + 200); end
            checks++;
            if ({output_valid, data_out} !== {exp_v, exp_d}) begin
                errors++;
                $display("FAIL loads i=%0d: got v=%0b d=%0d want v=%0b d=%0d", i, output_valid, data_out, exp_v, exp_d);
            end
            if (i == 1) begin
                checks++; if (delay_current !== 7'd10) begin errors++; $display("FAIL loads_dcur10: got %0d want 10", delay_current); end
            end
            if (i == 4) begin
                checks++; if (delay_current !== 7'd4) begin errors++; $display("FAIL loads_dcur4: got %0d want 4", delay_current); end
            end
            if (i == 8 || i == 9 || i == 16 || i == 20 || i == 21) begin
                checks++;
                if (delay_busy !== (i == 8 || i == 16 || i == 20)) begin
                    errors++;
                    $display("FAIL loads_busy i=%0d: got %0b want %0b", i, delay_busy, (i == 8 || i == 16 || i == 20));
                end
            end
            tick();
        end
        delay_load = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_ramp_and_change();
        test_d0();
        test_dmax();
        test_clamp();
        test_gaps();
        test_reset_midstream();
        test_back_to_back_loads();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
